// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the two-write / two-read register file.
//   rfState_t       : clear-sequencer state encoding
//   RF_DATA_W_DFLT  : default register width in bits
//   RF_DEPTH_DFLT   : default number of registers
// Build option: REGFILE_BYPASS_EN (consumed by regfile_2w2r, not used here).
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DATA_W_DFLT = 64;
    localparam int RF_DEPTH_DFLT  = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rfState_t;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// -----------------------------------------------------------------------------
// regfile_clear_seq
// Post-reset sequencer that walks every register index once so the top can
// zero the storage array, then declares the file usable.
// Ports:
//   CLK        in   clock, all state updates on posedge
//   RST_N      in   synchronous reset, active-low; restarts the walk at 0
//   clear_en   out  1 while the walk is in progress (registered)
//   clear_addr out  index being zeroed this cycle (registered)
//   ready      out  1 once the last index has been zeroed (registered)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RF_CLEAR | zeroing entry clear_addr this cycle, file not yet usable
// RF_READY | every entry has been zeroed, normal reads/writes allowed
// -----------------------------------------------------------------------------
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = RF_DEPTH_DFLT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              clear_en,
    output logic [ADDR_W-1:0] clear_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rfState_t state;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= RF_CLEAR;
            clear_addr <= '0;
            clear_en   <= 1'b1;
            ready      <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    clear_addr <= clear_addr + ADDR_W'(1);
                    // ready rises on the same edge that zeroes the last entry
                    if (clear_addr == LAST_ADDR) begin
                        state    <= RF_READY;
                        clear_en <= 1'b0;
                        ready    <= 1'b1;
                    end
                end
                RF_READY: begin
                    clear_en <= 1'b0;
                    ready    <= 1'b1;
                end
                default: begin
                    state      <= RF_CLEAR;
                    clear_addr <= '0;
                    clear_en   <= 1'b1;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

endmodule : regfile_clear_seq

// File: rtl/regfile_2w2r.sv
// -----------------------------------------------------------------------------
// regfile_2w2r
// General-purpose register file: two combinational read ports (Rn, Rm) and two
// synchronous write ports (port 0 = ALU result, port 1 = load data). Index
// ZERO_REG always reads 0 and ignores writes. After reset a sequencer zeroes
// one entry per cycle; until it finishes, reads return 0 and writes are lost.
// Ports:
//   CLK, RST_N               clock / synchronous active-low reset
//   Rn, Rm                   read addresses      -> dataRn, dataRm
//   Rd0, dataWrite0, regWR0  write port 0 (ALU)
//   Rd1, dataWrite1, regWR1  write port 1 (load), wins on same-address writes
//   ready                    1 = clear sequence done, file usable
//   wrConflict               1-cycle pulse after both ports wrote one non-zero Rd
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to
// the read ports (port 1 > port 0 > array). Without it, a read returns the old
// value until the cycle after the write edge.
// -----------------------------------------------------------------------------
module regfile_2w2r
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = RF_DATA_W_DFLT,
    parameter  int DEPTH    = RF_DEPTH_DFLT,
    localparam int ADDR_W   = $clog2(DEPTH),
    parameter  int ZERO_REG = DEPTH - 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] Rn,
    input  logic [ADDR_W-1:0] Rm,
    input  logic [ADDR_W-1:0] Rd0,
    input  logic [DATA_W-1:0] dataWrite0,
    input  logic              regWR0,
    input  logic [ADDR_W-1:0] Rd1,
    input  logic [DATA_W-1:0] dataWrite1,
    input  logic              regWR1,
    output logic [DATA_W-1:0] dataRn,
    output logic [DATA_W-1:0] dataRm,
    output logic              ready,
    output logic              wrConflict
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              clearEn;
    logic [ADDR_W-1:0] clearAddr;
    logic              wrEn0;
    logic              wrEn1;

    regfile_clear_seq #(
        .DEPTH (DEPTH)
    ) uClearSeq (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clear_en   (clearEn),
        .clear_addr (clearAddr),
        .ready      (ready)
    );

    // Zero-register writes are dropped here so they can neither land nor
    // count toward a conflict.
    assign wrEn0 = regWR0 && (Rd0 != ZERO_ADDR);
    assign wrEn1 = regWR1 && (Rd1 != ZERO_ADDR);

    // Port 1 is assigned last so it wins when both ports target one entry.
    // RST_N gates the write path because ready is still high on the first
    // reset edge taken from the READY state.
    always_ff @(posedge CLK) begin
        if (clearEn) begin
            regs[clearAddr] <= '0;
        end else if (ready && RST_N) begin
            if (wrEn0) begin
                regs[Rd0] <= dataWrite0;
            end
            if (wrEn1) begin
                regs[Rd1] <= dataWrite1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wrConflict <= 1'b0;
        end else begin
            wrConflict <= ready && wrEn0 && wrEn1 && (Rd0 == Rd1);
        end
    end

    always_comb begin
        dataRn = '0;
        if (ready && (Rn != ZERO_ADDR)) begin
            dataRn = regs[Rn];
`ifdef REGFILE_BYPASS_EN
            if (wrEn0 && (Rd0 == Rn)) begin
                dataRn = dataWrite0;
            end
            if (wrEn1 && (Rd1 == Rn)) begin
                dataRn = dataWrite1;
            end
`endif
        end
    end

    always_comb begin
        dataRm = '0;
        if (ready && (Rm != ZERO_ADDR)) begin
            dataRm = regs[Rm];
`ifdef REGFILE_BYPASS_EN
            if (wrEn0 && (Rd0 == Rm)) begin
                dataRm = dataWrite0;
            end
            if (wrEn1 && (Rd1 == Rm)) begin
                dataRm = dataWrite1;
            end
`endif
        end
    end

endmodule : regfile_2w2r
